// File: rtl/cg_reg_bank_if.sv
// Bundle of the data, enable and statistics signals of cg_reg_bank.
//   master : drives d_in, en, test_en, cnt_clr, cnt_sel
//            and observes d_out, gate_open, gated_cnt, total_cnt
//   slave  : the reg bank itself (mirror of master)
// clk and rst_n stay as plain ports on the block, outside this bundle.
interface cg_reg_bank_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] d_in;
  logic [CHANNELS-1:0]       en;
  logic                      test_en;
  logic                      cnt_clr;
  logic [SEL_W-1:0]          cnt_sel;
  logic [CHANNELS*WIDTH-1:0] d_out;
  logic [CHANNELS-1:0]       gate_open;
  logic [CNT_W-1:0]          gated_cnt;
  logic [CNT_W-1:0]          total_cnt;

  modport master (
    output d_in, en, test_en, cnt_clr, cnt_sel,
    input  d_out, gate_open, gated_cnt, total_cnt
  );

  modport slave (
    input  d_in, en, test_en, cnt_clr, cnt_sel,
    output d_out, gate_open, gated_cnt, total_cnt
  );
endinterface

// File: rtl/cg_reg_bank.sv
// Clock-gated register bank with gating statistics.
// Each channel has a latch-based clock gate (transparent while clk is low),
// a data register clocked by the gated clock, and a counter of the cycles in
// which its gate was closed. A free-running cycle counter runs alongside.
// Ports:
//   clk    : free-running clock
//   rst_n  : asynchronous active-low reset (synchronised upstream)
//   bus    : cg_reg_bank_if.slave
//            d_in/en/test_en/cnt_clr/cnt_sel in,
//            d_out/gate_open/gated_cnt/total_cnt out
module cg_reg_bank #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cg_reg_bank_if.slave  bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] r_en_lat;
  logic [CHANNELS-1:0] w_gclk;
  logic [WIDTH-1:0]    r_data [CHANNELS];
  logic [CNT_W-1:0]    r_gcnt [CHANNELS];
  logic [CNT_W-1:0]    r_total;
  logic [CNT_W-1:0]    w_gated_cnt;

  // Enable latch is transparent only in the low phase, so any enable change
  // while clk is high is held off until after the falling edge; the AND gate
  // below therefore never sees a partial pulse.
  always_latch begin
    if (!rst_n)
      r_en_lat <= '0;
    else if (!clk)
      r_en_lat <= bus.en | {CHANNELS{bus.test_en}};
  end

  assign w_gclk        = {CHANNELS{clk}} & r_en_lat;
  assign bus.gate_open = r_en_lat;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    always_ff @(posedge w_gclk[g] or negedge rst_n) begin
      if (!rst_n)
        r_data[g] <= '0;
      else
        r_data[g] <= bus.d_in[g*WIDTH +: WIDTH];
    end

    assign bus.d_out[g*WIDTH +: WIDTH] = r_data[g];

    // Counts on the ungated clock; the latch is closed during the high
    // phase, so the value seen at the rising edge is the one that gated it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_gcnt[g] <= '0;
      else if (bus.cnt_clr)
        r_gcnt[g] <= '0;
      else if (!r_en_lat[g] && (r_gcnt[g] != CNT_MAX))
        r_gcnt[g] <= r_gcnt[g] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_total <= '0;
    else if (bus.cnt_clr)
      r_total <= '0;
    else if (r_total != CNT_MAX)
      r_total <= r_total + 1'b1;
  end

  // Compare-based mux: selects beyond the last channel fall through to 0.
  always_comb begin
    w_gated_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.cnt_sel == SEL_W'(i))
        w_gated_cnt = r_gcnt[i];
    end
  end

  assign bus.gated_cnt = w_gated_cnt;
  assign bus.total_cnt = r_total;

endmodule

// File: doc/cg_reg_bank.md
CG_REG_BANK -- requirements
Module: cg_reg_bank

Interface
REQ-001 The block SHALL be parameterised as follows (name, default, meaning):
- WIDTH, 1, bits per channel
- CHANNELS, 2, number of independently gated channels (1..16)
- CNT_W, 16, width of each statistics counter
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the reset port SHALL be named rst_n.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  free-running clock
- rst_n  in  1  asynchronous active-low reset
- d_in  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- en  in  CHANNELS  per-channel load enable, drives that channel's clock gate
- test_en  in  1  forces every gate open (scan/test)
- cnt_clr  in  1  synchronous clear of all statistics counters
- cnt_sel  in  max(1,clog2(CHANNELS))  selects the channel reported on gated_cnt
- d_out  out  CHANNELS*WIDTH  registered channel data
- gate_open  out  CHANNELS  latched gate enable per channel
- gated_cnt  out  CNT_W  gated-cycle count of the selected channel
- total_cnt  out  CNT_W  clk cycles since the last clear or reset

Function
REQ-004 Each channel SHALL contain one latch-based clock gate: en_lat[i] follows (en[i] | test_en) while clk is low and holds while clk is high.
REQ-005 Each gated clock SHALL be gclk[i] = clk & en_lat[i], so that a change on en[i] or test_en during the clk-high phase produces no glitch or partial pulse.
REQ-006 gate_open[i] SHALL equal en_lat[i].
REQ-007 On each rising edge of gclk[i], d_out slice i SHALL capture d_in slice i; it SHALL hold in all other cycles.
REQ-008 Load latency SHALL be one edge: if en[i]=1 is stable through the low phase before edge k, d_out slice i shows the value of d_in present at edge k immediately after edge k.
REQ-009 Channels SHALL be fully independent; any mix of en bits (including all ones or all zeros) SHALL be legal.
REQ-010 test_en=1 SHALL load every channel on every clk edge, regardless of en.
REQ-011 Per-channel counter gcnt[i], clocked by ungated clk, SHALL increment on each clk rising edge where en_lat[i]=0.
REQ-012 total_cnt SHALL increment on every clk rising edge.
REQ-013 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-014 cnt_clr=1 at a clk edge SHALL set all counters to 0; clear SHALL take priority over a simultaneous increment.
REQ-015 gated_cnt SHALL be a combinational mux of gcnt[cnt_sel]; cnt_sel >= CHANNELS SHALL return 0.
REQ-016 d_out and the counters SHALL change only on clock edges or on reset.

Reset
REQ-017 While rst_n=0, all of the following SHALL be 0:
- d_out
- gate_open / en_lat (all gated clocks held low)
- every gcnt
- total_cnt
REQ-018 Reset assertion mid-operation SHALL take effect immediately and override any in-flight load or count.
REQ-019 rst_n deassertion SHALL be synchronised upstream; the block SHALL NOT resynchronise it.
REQ-020 The first clk edge after deassertion SHALL be treated as a normal edge.

Verification
REQ-021 Basic gating (CHANNELS=2, WIDTH=1):
- Stimulus: en=01, d_in=11 for one edge, then en=00, d_in=00 for 5 edges.
- Response: d_out=01 and held; gcnt[1]=6, gcnt[0]=5, total_cnt=6.
REQ-022 Glitch check:
- Stimulus: toggle en[0] 0->1->0 entirely within one clk-high phase.
- Response: no gclk[0] pulse, d_out unchanged, gate_open[0] stays 0.
REQ-023 Test mode:
- Stimulus: test_en=1, en=00, d_in=10.
- Response: d_out=10 after one edge; gcnt unchanged while test_en=1.
REQ-024 Saturation and clear (CNT_W=4):
- Stimulus: hold en=00 for 20 edges, then assert cnt_clr on the 21st edge.
- Response: gcnt and total_cnt stop at 15, then read 0 after the clearing edge.
REQ-025 Mid-operation reset:
- Stimulus: drop rst_n asynchronously between edges with d_out=11 and counters nonzero.
- Response: all outputs go to 0 immediately; after release, normal loading resumes on the first edge.
REQ-026 Select bounds:
- Stimulus: CHANNELS=3, cnt_sel=3.
- Response: gated_cnt=0.
